spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
- Parametrised SPI slave that runs on one system clock. It oversamples `sclk`, `cs_n` and `mosi` through synchronisers instead of clocking logic on `sclk`.
- Supports all four SPI modes (CPOL/CPHA selected at run time).
- Supports back-to-back multi-word frames within one `cs_n` assertion.
- Exchanges words with the core through valid/ready handshakes on both TX and RX.
- Sits between the chip pins and the register/bus front-end. It is the synchronous replacement for the original `sclk`-clocked slave.

Parameters:
- WIDTH, 8, bits per SPI word (2..32).
- SYNC_STAGES, 2, flops in each input synchroniser (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  serial clock from master (asynchronous to clk).
- cs_n  in  1  chip select, active low (asynchronous).
- mosi  in  1  master-out serial data.
- miso  out  1  slave-out serial data, MSB first.
- miso_oe  out  1  output enable for the `miso` pad driver.
- cpol  in  1  clock idle level; sampled on cs_n falling edge.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled on cs_n falling edge.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX holding register is empty.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  core accepts rx_data.
- busy  out  1  frame in progress (synchronised cs_n is low).
- frame_done  out  1  one-clk pulse when synchronised cs_n rises.
- tx_underrun  out  1  one-clk pulse when a word starts with the holding register empty.

Behaviour:
- **Reset values:** miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0, frame_done=0, tx_underrun=0. All internal registers are cleared.
- **Reset mid-operation:** takes effect immediately (asynchronous). The partial word is lost and the block stays idle until the next cs_n fall.
- **Input synchronisation:** sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronised value with the previous one.
- **Clock ratio:** required f_clk ≥ 4·f_sclk. Required cs_n setup to the first sclk edge ≥ (SYNC_STAGES+2) clk periods.
- **Edge mapping:**
  - Leading edge = rising edge if cpol=0, falling edge if cpol=1. The trailing edge is the opposite.
  - Sample edge = leading edge if cpha=0, otherwise trailing.
  - Shift edge = the other edge.
- **State machine:**
  - IDLE → ACTIVE on synchronised cs_n fall.
  - ACTIVE → IDLE on synchronised cs_n rise.
  - Mode bits and busy=1 are latched on the IDLE → ACTIVE transition.
- **Word start** (entry to ACTIVE, or completion of the previous word):
  - If the holding register is full, the shift-out register loads from it, the holding register is emptied, and tx_ready=1 the next cycle.
  - If the holding register is empty, all-zeros are loaded and tx_underrun pulses.
- **Driving miso:**
  - cpha=0: the MSB is driven on miso within 1 clk of the ACTIVE entry. Subsequent bits are driven on shift edges.
  - cpha=1: the first bit is driven on the first shift edge (leading edge).
  - miso_oe=1 throughout ACTIVE.
- **Receiving:** on each sample edge, synchronised mosi shifts into the RX shift register (MSB first) and the bit counter increments.
- **Word completion:** when the bit counter reaches WIDTH on a sample edge, the counter wraps to 0.
  - If rx_valid=0, rx_data ← shift register and rx_valid=1 the next clk.
  - If rx_valid=1 (overrun), the new word is dropped and rx_data is held unchanged.
- **RX handshake:** rx_valid clears on the cycle after rx_valid && rx_ready. A simultaneous handshake and new word in the same clk is not an overrun; the new word is stored.
- **TX handshake:** tx_valid && tx_ready loads the holding register and drops tx_ready. A load in the same clk as a word start is used by that word (bypass).
- **Frame end:** cs_n rise in ACTIVE gives frame_done pulse, miso=0, miso_oe=0 and busy=0. Any partial word is discarded and not delivered. The holding register is kept.
- **Edges outside a frame:** sclk edges in IDLE are ignored.

Optional Feature:
- Macro: SPI_SLAVE_SYNC_OVERRUN_EN.
- When defined, two extra outputs are added:
  - rx_overrun (1 bit): sticky; set when a word is dropped; cleared by the input ovr_clr (1 bit, pulse).
  - ovr_count (8 bits): counts dropped words, saturating at 255; cleared by ovr_clr.
- When not defined, these ports and their logic are absent. Dropped words are silently lost.

Test Plan:
- **Mode 0, single word:** WIDTH=8, cpol=0, cpha=0, tx 0x3C preloaded, master sends 0xA5 → rx_data=0xA5 with rx_valid=1; master receives 0x3C; frame_done pulses once.
- **Mode 3:** cpol=1, cpha=1, tx 0x81, master sends 0x7E → rx_data=0x7E; master receives 0x81; miso_oe=0 after cs_n rise.
- **Multi-word frame:** tx 0x11 then 0x22 supplied via handshake, master sends 0xDE,0xAD in one cs_n → two rx_valid events 0xDE, 0xAD; master receives 0x11,0x22; no tx_underrun.
- **Underrun and overrun:** two-word frame, tx loaded for word 1 only, rx_ready held 0 → tx_underrun pulses at word 2 start and word 2 returns 0x00; rx_data stays at word 1. With SPI_SLAVE_SYNC_OVERRUN_EN defined, rx_overrun=1 and ovr_count=1.
- **Abort:** cs_n rises after 3 bits of 0xF0 → no rx_valid; frame_done pulses; the next full frame receives 0x5A correctly.
- **Reset mid-word:** rst_n low after 4 bits → all outputs at reset values immediately; the next frame completes normally.

Source files
------------

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: SPI pad signals plus core-side TX/RX valid/ready handshakes.
// Ports (slave view):
//   in : sclk, cs_n, mosi, cpol, cpha, tx_data, tx_valid, rx_ready
//   out: miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_done, tx_underrun
// Optional macro SPI_SLAVE_SYNC_OVERRUN_EN adds:
//   in : ovr_clr
//   out: rx_overrun, ovr_count[7:0]
interface spi_slave_sync_if #(
    parameter int WIDTH = 8
);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic             cpol;
    logic             cpha;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             busy;
    logic             frame_done;
    logic             tx_underrun;
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    logic             ovr_clr;
    logic             rx_overrun;
    logic [7:0]       ovr_count;
`endif

    modport slave (
        input  sclk, cs_n, mosi, cpol, cpha,
        input  tx_data, tx_valid, rx_ready,
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        input  ovr_clr,
        output rx_overrun, ovr_count,
`endif
        output miso, miso_oe, tx_ready,
        output rx_data, rx_valid,
        output busy, frame_done, tx_underrun
    );

    modport master (
        output sclk, cs_n, mosi, cpol, cpha,
        output tx_data, tx_valid, rx_ready,
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        output ovr_clr,
        input  rx_overrun, ovr_count,
`endif
        input  miso, miso_oe, tx_ready,
        input  rx_data, rx_valid,
        input  busy, frame_done, tx_underrun
    );
endinterface

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave (modes 0-3) running entirely on clk; sclk/cs_n/mosi
// are oversampled through SYNC_STAGES-deep synchronisers.
// Ports: clk, rst_n (async, active low), bus (spi_slave_sync_if.slave).
// Optional macro SPI_SLAVE_SYNC_OVERRUN_EN: sticky rx_overrun, saturating
// ovr_count, both cleared by ovr_clr.
module spi_slave_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_sync_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic                   r_cpol;
    logic                   r_cpha;
    logic [CW-1:0]          r_bit_cnt;
    logic [WIDTH-1:0]       r_rx_sr;
    logic [WIDTH-1:0]       r_rx_data;
    logic                   r_rx_valid;
    logic [WIDTH-1:0]       r_hold;
    logic                   r_hold_full;
    logic [WIDTH-1:0]       r_tx_sr;
    logic                   r_miso;
    logic                   r_pend;
    logic                   r_uflow_pend;
    logic                   r_underrun;
    logic                   r_frame_done;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_enter;
    logic                   w_leave;
    logic                   w_act_edge;
    logic                   w_smp;
    logic                   w_shf;
    logic                   w_word_done;
    logic [WIDTH-1:0]       w_rx_word;
    logic                   w_rx_take;
    logic                   w_rx_store;
    logic                   w_tx_hs;
    logic                   w_load;
    logic [WIDTH-1:0]       w_tx_src;
    logic                   w_tx_empty;

    // Input synchronisers and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    assign w_lead   = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = r_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_shift  = r_cpha ? w_lead : w_trail;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and frame strobes
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_ACTIVE;
                    w_enter     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_leave     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A cs_n rise wins over an sclk edge seen in the same clk
    assign w_act_edge  = (r_state == S_ACTIVE) && !w_cs_rise;
    assign w_smp       = w_act_edge && w_sample;
    assign w_shf       = w_act_edge && w_shift;
    assign w_word_done = w_smp && (r_bit_cnt == CW'(WIDTH - 1));
    assign w_rx_word   = {r_rx_sr[WIDTH-2:0], w_mosi_s};
    assign w_rx_take   = r_rx_valid && bus.rx_ready;
    assign w_rx_store  = w_word_done && (!r_rx_valid || w_rx_take);

    // A pending word start is resolved on the next shift edge: that is where
    // its MSB must appear on miso. With cpha=0 the first word of a frame is
    // resolved on entry instead, so the MSB is ready before the first edge.
    assign w_tx_hs    = bus.tx_valid && !r_hold_full;
    assign w_load     = (w_enter && !bus.cpha) || (w_shf && r_pend);
    assign w_tx_src   = r_hold_full ? r_hold
                      : (w_tx_hs ? bus.tx_data : '0);
    assign w_tx_empty = !r_hold_full && !w_tx_hs;

    // Mode latch, bit counter and RX shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_bit_cnt <= '0;
            r_rx_sr   <= '0;
        end else begin
            if (w_enter) begin
                r_cpol <= bus.cpol;
                r_cpha <= bus.cpha;
            end
            if (w_enter || w_leave) begin
                r_bit_cnt <= '0;
                r_rx_sr   <= '0;
            end else if (w_smp) begin
                r_rx_sr   <= w_rx_word;
                r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CW'(1);
            end
        end
    end

    // RX output register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_rx_store) begin
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
            end else if (w_rx_take) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // TX holding register; a load coinciding with a word start bypasses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_tx_hs && !w_load) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // TX shift register and miso driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sr <= '0;
            r_miso  <= 1'b0;
        end else begin
            if (w_leave) begin
                r_miso <= 1'b0;
            end else if (w_load) begin
                r_miso  <= w_tx_src[WIDTH-1];
                r_tx_sr <= w_tx_src << 1;
            end else if (w_shf) begin
                r_miso  <= r_tx_sr[WIDTH-1];
                r_tx_sr <= r_tx_sr << 1;
            end
        end
    end

    // Word-start bookkeeping. An empty-holding word start is only reported
    // once that word's first bit is sampled, so the speculative start after
    // the last word of a frame does not raise a false underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= 1'b0;
            r_uflow_pend <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_underrun   <= w_smp && r_uflow_pend;
            r_frame_done <= w_leave;
            if (w_leave) begin
                r_pend <= 1'b0;
            end else if (w_enter) begin
                r_pend <= bus.cpha;
            end else if (w_word_done) begin
                r_pend <= 1'b1;
            end else if (w_load) begin
                r_pend <= 1'b0;
            end
            if (w_leave) begin
                r_uflow_pend <= 1'b0;
            end else if (w_load) begin
                r_uflow_pend <= w_tx_empty;
            end else if (w_smp) begin
                r_uflow_pend <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    logic       w_rx_drop;
    logic       r_rx_overrun;
    logic [7:0] r_ovr_count;

    assign w_rx_drop = w_word_done && r_rx_valid && !w_rx_take;

    // A drop in the same clk as a clear is still recorded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_overrun <= 1'b0;
            r_ovr_count  <= '0;
        end else begin
            if (bus.ovr_clr) begin
                r_rx_overrun <= w_rx_drop;
                r_ovr_count  <= {7'd0, w_rx_drop};
            end else if (w_rx_drop) begin
                r_rx_overrun <= 1'b1;
                if (r_ovr_count != 8'hFF) begin
                    r_ovr_count <= r_ovr_count + 8'd1;
                end
            end
        end
    end

    assign bus.rx_overrun = r_rx_overrun;
    assign bus.ovr_count  = r_ovr_count;
`endif

    assign bus.miso        = r_miso;
    assign bus.miso_oe     = (r_state == S_ACTIVE);
    assign bus.busy        = (r_state == S_ACTIVE);
    assign bus.tx_ready    = !r_hold_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.frame_done  = r_frame_done;
    assign bus.tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master stimulus for spi_slave_sync
// (WIDTH=8, SYNC_STAGES=2, sclk = clk/16).
module tb_spi_slave_sync;
    localparam int H = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpol  = 1'b0;
    logic       cpha  = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         fd_cnt = 0;
    int         uf_cnt = 0;
    int         cap_n  = 0;
    logic [7:0] cap [0:7];
    logic [7:0] mi0;
    logic [7:0] mi1;

    spi_slave_sync_if #(.WIDTH(8)) bus ();

    spi_slave_sync #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.cpol = cpol;
    assign bus.cpha = cpha;

    always @(negedge clk) begin
        if (bus.frame_done) fd_cnt++;
        if (bus.tx_underrun) uf_cnt++;
        if (bus.rx_valid && bus.rx_ready) begin
            if (cap_n < 8) cap[cap_n] = bus.rx_data;
            cap_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tx_load(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol     = pol;
        cpha     = pha;
        bus.sclk = pol;
        tick(H);
    endtask

    task automatic cs_fall();
        bus.cs_n = 1'b0;
        tick(H);
    endtask

    task automatic cs_rise();
        tick(H);
        bus.cs_n = 1'b1;
        tick(H);
    endtask

    task automatic rx_consume();
        bus.rx_ready = 1'b1;
        tick(2);
        bus.rx_ready = 1'b0;
        tick(1);
    endtask

    // Master side of nb bits, MSB first
    task automatic xfer(input logic [7:0] mo, input int nb,
                        output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!cpha) begin
                bus.mosi = mo[i];
                tick(H);
                bus.sclk = ~cpol;
                mi[i]    = bus.miso;
                tick(H);
                bus.sclk = cpol;
            end else begin
                bus.sclk = ~cpol;
                bus.mosi = mo[i];
                tick(H);
                bus.sclk = cpol;
                mi[i]    = bus.miso;
                tick(H);
            end
        end
    endtask

    initial begin
        bus.sclk     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        bus.ovr_clr  = 1'b0;
`endif
        tick(3);
        chk("rst_miso", bus.miso, 0);
        chk("rst_miso_oe", bus.miso_oe, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_underrun", bus.tx_underrun, 0);
        rst_n = 1'b1;
        tick(4);

        // Mode 0, single word
        set_mode(1'b0, 1'b0);
        fd_cnt = 0;
        uf_cnt = 0;
        tx_load(8'h3C);
        chk("m0_tx_ready_full", bus.tx_ready, 0);
        cs_fall();
        chk("m0_busy", bus.busy, 1);
        chk("m0_miso_oe", bus.miso_oe, 1);
        chk("m0_tx_ready_empty", bus.tx_ready, 1);
        xfer(8'hA5, 8, mi0);
        cs_rise();
        chk("m0_miso_word", mi0, 8'h3C);
        chk("m0_rx_valid", bus.rx_valid, 1);
        chk("m0_rx_data", bus.rx_data, 8'hA5);
        chk("m0_frame_done", fd_cnt, 1);
        chk("m0_busy_end", bus.busy, 0);
        chk("m0_underrun", uf_cnt, 0);
        rx_consume();
        chk("m0_rx_consumed", bus.rx_valid, 0);

        // Mode 3
        set_mode(1'b1, 1'b1);
        fd_cnt = 0;
        tx_load(8'h81);
        cs_fall();
        xfer(8'h7E, 8, mi0);
        cs_rise();
        chk("m3_miso_word", mi0, 8'h81);
        chk("m3_rx_data", bus.rx_data, 8'h7E);
        chk("m3_rx_valid", bus.rx_valid, 1);
        chk("m3_miso_oe_end", bus.miso_oe, 0);
        chk("m3_miso_end", bus.miso, 0);
        chk("m3_frame_done", fd_cnt, 1);
        rx_consume();

        // Multi-word frame, mode 0, rx_ready held high
        set_mode(1'b0, 1'b0);
        bus.rx_ready = 1'b1;
        tick(2);
        cap_n  = 0;
        uf_cnt = 0;
        tx_load(8'h11);
        cs_fall();
        tx_load(8'h22);
        xfer(8'hDE, 8, mi0);
        xfer(8'hAD, 8, mi1);
        cs_rise();
        bus.rx_ready = 1'b0;
        chk("mw_rx_count", cap_n, 2);
        chk("mw_rx0", cap[0], 8'hDE);
        chk("mw_rx1", cap[1], 8'hAD);
        chk("mw_miso0", mi0, 8'h11);
        chk("mw_miso1", mi1, 8'h22);
        chk("mw_underrun", uf_cnt, 0);

        // Underrun and overrun
        tick(2);
        uf_cnt = 0;
        tx_load(8'hC3);
        cs_fall();
        xfer(8'h96, 8, mi0);
        xfer(8'h69, 8, mi1);
        cs_rise();
        chk("ur_miso0", mi0, 8'hC3);
        chk("ur_miso1", mi1, 8'h00);
        chk("ur_underrun", uf_cnt, 1);
        chk("ov_rx_data", bus.rx_data, 8'h96);
        chk("ov_rx_valid", bus.rx_valid, 1);
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        chk("ov_flag", bus.rx_overrun, 1);
        chk("ov_count", bus.ovr_count, 1);
        bus.ovr_clr = 1'b1;
        tick(1);
        bus.ovr_clr = 1'b0;
        tick(1);
        chk("ov_flag_clr", bus.rx_overrun, 0);
        chk("ov_count_clr", bus.ovr_count, 0);
`endif
        rx_consume();

        // Abort after 3 bits, then a full frame
        fd_cnt = 0;
        cs_fall();
        xfer(8'hF0, 3, mi0);
        cs_rise();
        chk("ab_frame_done", fd_cnt, 1);
        chk("ab_rx_valid", bus.rx_valid, 0);
        chk("ab_busy", bus.busy, 0);
        tx_load(8'hE1);
        cs_fall();
        xfer(8'h5A, 8, mi0);
        cs_rise();
        chk("ab_next_rx_data", bus.rx_data, 8'h5A);
        chk("ab_next_rx_valid", bus.rx_valid, 1);
        chk("ab_next_miso", mi0, 8'hE1);

        // Reset mid-word, with an unconsumed RX word and a full holding reg
        tx_load(8'hB4);
        cs_fall();
        tx_load(8'hC6);
        xfer(8'h33, 4, mi0);
        tick(2);
        chk("rw_pre_miso_oe", bus.miso_oe, 1);
        chk("rw_pre_tx_ready", bus.tx_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rw_miso_oe", bus.miso_oe, 0);
        chk("rw_miso", bus.miso, 0);
        chk("rw_busy", bus.busy, 0);
        chk("rw_tx_ready", bus.tx_ready, 1);
        chk("rw_rx_valid", bus.rx_valid, 0);
        chk("rw_rx_data", bus.rx_data, 0);
        bus.cs_n = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(H);
        chk("rw_idle_busy", bus.busy, 0);
        fd_cnt = 0;
        tx_load(8'h69);
        cs_fall();
        xfer(8'hC3, 8, mi0);
        cs_rise();
        chk("rw_next_rx_data", bus.rx_data, 8'hC3);
        chk("rw_next_rx_valid", bus.rx_valid, 1);
        chk("rw_next_miso", mi0, 8'h69);
        chk("rw_next_frame_done", fd_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
